// File: rtl/ladder_pkg.sv
// ladder_pkg: shared widths, step classes and result record for the ladder monitor
package ladder_pkg;
    localparam int CUR_W = 4;
    localparam int PERIOD_W = 8;
    typedef logic [CUR_W-1:0] cur_t;
    typedef logic [PERIOD_W-1:0] period_t;
    typedef enum logic [2:0] {
        STEP_UP,
        STEP_DOWN,
        STEP_STALL,
        STEP_PEAK,
        STEP_VALLEY,
        STEP_ILLEGAL
    } step_t;
    typedef struct packed {
        cur_t    peak;
        period_t period;
        logic    err;
    } ladder_result_t;
endpackage

// File: rtl/ladder_result_fifo.sv
// ladder_result_fifo: synchronous FIFO of ladder results; head reads as zero when empty
module ladder_result_fifo
    import ladder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           push,
    input  ladder_result_t din,
    input  logic           pop,
    output ladder_result_t dout,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);
    ladder_result_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ladder_monitor.sv
// ladder_monitor: classifies ladder steps, measures valley-to-valley periods and queues result records
module ladder_monitor #(
    parameter int CUR_W = ladder_pkg::CUR_W,
    parameter int PERIOD_W = ladder_pkg::PERIOD_W,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CUR_W-1:0]    cur_in,
    input  logic                dir_in,
    input  logic                clear,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CUR_W-1:0]    res_peak,
    output logic [PERIOD_W-1:0] res_period,
    output logic                res_err,
    output logic                err_sticky,
    output logic [PERIOD_W-1:0] err_count,
    output logic                overrun
);
    import ladder_pkg::*;
    cur_t prev_cur, peak_reg;
    period_t period_cnt;
    logic prev_dir, seen_valley, per_err;
    step_t step;
    logic illegal, valley, push, pop, full, empty;
    ladder_result_t head;
    always_comb begin
        step = (dir_in == prev_dir && cur_in == prev_cur) ? STEP_STALL :
               (dir_in && prev_dir && cur_in == prev_cur + cur_t'(1)) ? STEP_UP :
               (!dir_in && !prev_dir && cur_in == prev_cur - cur_t'(1)) ? STEP_DOWN :
               (prev_dir && !dir_in && cur_in == prev_cur - cur_t'(1)) ? STEP_PEAK :
               (!prev_dir && dir_in && cur_in == prev_cur) ? STEP_VALLEY : STEP_ILLEGAL;
    end
    assign illegal = step == STEP_ILLEGAL;
    assign valley = step == STEP_VALLEY;
    assign push = valley && seen_valley;
    assign pop = res_valid && res_ready;
    assign res_valid = !empty;
    assign res_peak = head.peak;
    assign res_period = head.period;
    assign res_err = head.err;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_cur <= '0;
            prev_dir <= 1'b1;
            seen_valley <= 1'b0;
            period_cnt <= '0;
            peak_reg <= '0;
            per_err <= 1'b0;
            err_sticky <= 1'b0;
            err_count <= '0;
            overrun <= 1'b0;
        end else begin
            prev_cur <= cur_in;
            prev_dir <= dir_in;
            if (step == STEP_PEAK) peak_reg <= prev_cur;
            period_cnt <= valley ? period_t'(1) : (&period_cnt) ? period_cnt : period_cnt + period_t'(1);
            per_err <= valley ? 1'b0 : (per_err || illegal);
            seen_valley <= seen_valley || valley;
            err_sticky <= !clear && (err_sticky || illegal);
            err_count <= clear ? '0 : (illegal && !(&err_count)) ? err_count + period_t'(1) : err_count;
            // a record pushed into a full FIFO is lost unless the head leaves in the same cycle
            overrun <= !clear && (overrun || (push && full && !pop));
        end
    end
    ladder_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .resetn(resetn),
        .push(push),
        .din('{peak: peak_reg, period: period_cnt, err: per_err}),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );
endmodule

// File: doc/ladder_monitor.md
Name: ladder_monitor

Overview:
- Sits directly downstream of the ladder counter. Consumes its per-cycle current/direction stream.
- Detects peaks (up-to-down turn) and valleys (down-to-up turn) and measures ladder period in clocks.
- Checks every step for legality.
- Emits one result record per completed ladder period through a valid/ready port, buffered in a small FIFO.

Parameters:
- CUR_W, 4, width of the current value (matches the ladder counter).
- PERIOD_W, 8, width of the period and error counters (both saturating).
- DEPTH, 2, result FIFO depth in entries (power of two, >=2).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- cur_in  in  CUR_W  ladder current value, sampled every clk
- dir_in  in  1  ladder direction (1 = up, 0 = down)
- clear  in  1  synchronous clear of sticky flags and error counter
- res_valid  out  1  FIFO head holds a result
- res_ready  in  1  consumer accepts head this cycle
- res_peak  out  CUR_W  peak value of the reported period
- res_period  out  PERIOD_W  period length in clocks
- res_err  out  1  at least one illegal step occurred within the reported period
- err_sticky  out  1  an illegal step has occurred since reset/clear
- err_count  out  PERIOD_W  number of illegal steps, saturating
- overrun  out  1  sticky; a result was dropped because the FIFO was full

Behaviour:
- Reset (async, resetn=0): all outputs are 0, the FIFO is empty, prev_cur=0, prev_dir=1, seen_valley=0, period_cnt=0, peak_reg=0, per_err=0.
- Every clk registers prev_cur<=cur_in and prev_dir<=dir_in. All checks compare cur_in/dir_in against prev_*. Arithmetic is mod 2^CUR_W.
- Step classes, evaluated each cycle:
  - up: dir=prev_dir=1, cur=prev_cur+1.
  - down: dir=prev_dir=0, cur=prev_cur-1.
  - stall: dir=prev_dir, cur=prev_cur. Legal; covers idle upstream.
  - peak: prev_dir=1, dir=0, cur=prev_cur-1.
  - valley: prev_dir=0, dir=1, cur=prev_cur.
  - Anything else is illegal: err_count+1 (saturate at all-ones), err_sticky<=1, per_err<=1.
- Peak event: peak_reg<=prev_cur.
- Period counter: increments each cycle and saturates at all-ones.
- Valley event:
  - If seen_valley=1: push {peak_reg, period_cnt, per_err} into the FIFO.
  - In all cases: seen_valley<=1, period_cnt<=1, per_err<=0.
  - The first valley after reset only arms the measurement; nothing is pushed.
  - An illegal step in the same cycle as a valley counts in err_count but goes into the next period's per_err, not the pushed record.
- Period definition: for a ladder that rises 1..D and falls back to 1 (D>=2), res_period=2*D-1 and res_peak=D.
- FIFO:
  - res_* outputs are driven from the head entry.
  - Pop when res_valid & res_ready.
  - Push while full without a same-cycle pop: the record is dropped, overrun<=1, contents are unchanged.
  - Push and pop in the same cycle when full: both succeed.
  - res_valid is asserted the cycle after the push, so latency from valley to res_valid is 1 clk.
  - res_* stay stable while res_valid=1 and res_ready=0.
- clear=1: err_sticky, err_count and overrun go to 0 next cycle. The FIFO and measurement state are untouched. If an error or overrun occurs in the same cycle as clear, clear wins.
- Reset mid-operation: everything returns to reset values, and the next valley only re-arms measurement.

Decomposition:
- Shared package ladder_pkg holds:
  - CUR_W default and the cur_t type.
  - Step-class enum: STEP_UP, STEP_DOWN, STEP_STALL, STEP_PEAK, STEP_VALLEY, STEP_ILLEGAL.
  - Packed struct ladder_result_t: peak, period, err.
- One sub-module, ladder_result_fifo: a synchronous FIFO of ladder_result_t with DEPTH entries and push/pop/full/empty.
- Step classification and counters live in the top level.

Test Plan:
- Upstream delta=3, res_ready=1 -> first valley produces no record; each later valley gives res_peak=3, res_period=5, res_err=0, 1 clk after the valley; err_count=0.
- Delta=5 steady -> records peak=5, period=9. Switch to delta=3 at a valley -> the next record is peak=3, period=5.
- Inject cur_in jump 2->4 while dir=1 -> err_count=1, err_sticky=1, and the enclosing period record has res_err=1; the following record has res_err=0.
- res_ready=0 across 3 valleys with DEPTH=2 -> 2 records held, the third dropped, overrun=1. Raise res_ready -> records come out in order, then res_valid=0.
- Hold cur_in=0, dir_in=1 for 20 clks (delta=0) -> no errors, no records. Pulse clear after an error -> err_count=0, err_sticky=0 next cycle.
- Assert resetn=0 mid-ladder with one record in the FIFO -> res_valid=0 immediately; after release, the first valley pushes nothing.
